// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver feeding a first-word-fall-through FIFO.
//               The head byte is presented with valid/empty status; a byte
//               is consumed whenever m_in is high while the FIFO holds data.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int CLK_PER_BIT = 868,
    parameter int DEPTH       = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rxd,
    input  logic       m_in,
    output logic [7:0] uart_in,
    output logic       uart_ok_in,
    output logic       empty,
    output logic       full,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(CLK_PER_BIT);

    localparam logic [CW-1:0] c_half_load = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] c_full_load = CW'(CLK_PER_BIT - 1);
    localparam logic [AW:0]   c_depth     = (AW + 1)'(DEPTH);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    // Synchroniser and edge-detect copy
    logic rx_meta_q, rx_s_q, rx_d_q;

    // Receiver state
    logic [1:0]    state_q,   state_d;
    logic [CW-1:0] baud_q,    baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q,   shift_d;
    logic          ferr_q,    ferr_d;
    logic          w_push;

    // FIFO state
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q,  rd_ptr_d;
    logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
    logic [AW:0]   count_q,   count_d;
    logic [7:0]    uart_in_q, uart_in_d;
    logic          ovf_q,     ovf_d;
    logic          w_empty, w_full, w_pop, w_wr_en;
    logic [AW-1:0] w_rd_next;

    // Two-flop synchroniser on rxd plus one delayed copy for falling-edge detection
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_s_q    <= rx_meta_q;
            rx_d_q    <= rx_s_q;
        end
    end

    // Receiver FSM: mid-bit sampling, LSB first, stop bit validates the byte
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        ferr_d    = 1'b0;
        w_push    = 1'b0;
        case (state_q)
            c_st_idle: begin
                if (rx_d_q && !rx_s_q) begin
                    baud_d  = c_half_load;
                    state_d = c_st_start;
                end
            end
            c_st_start: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CW'(1);
                end else if (!rx_s_q) begin
                    baud_d    = c_full_load;
                    bit_idx_d = 3'd0;
                    state_d   = c_st_data;
                end else begin
                    // Line back high at mid start bit: glitch, not a frame
                    state_d = c_st_idle;
                end
            end
            c_st_data: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CW'(1);
                end else begin
                    shift_d[bit_idx_q] = rx_s_q;
                    baud_d             = c_full_load;
                    if (bit_idx_q == 3'd7) begin
                        state_d = c_st_stop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            c_st_stop: begin
                if (baud_q != '0) begin
                    baud_d = baud_q - CW'(1);
                end else begin
                    // A low stop bit drops the byte; IDLE then waits for a
                    // fresh falling edge so a held break flags only once.
                    if (rx_s_q) begin
                        w_push = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // Receiver registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= c_st_idle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            ferr_q    <= ferr_d;
        end
    end

    // FIFO control: pop/push arbitration, overflow, and the registered head byte
    always_comb begin
        w_empty   = (count_q == '0);
        w_full    = (count_q == c_depth);
        w_pop     = m_in && !w_empty;
        // A simultaneous pop frees the slot, so a push while full is accepted then
        w_wr_en   = w_push && (!w_full || w_pop);
        w_rd_next = rd_ptr_q + AW'(1);

        mem_d = mem_q;
        if (w_wr_en) begin
            mem_d[wr_ptr_q] = shift_q;
        end

        rd_ptr_d = w_pop   ? w_rd_next : rd_ptr_q;
        wr_ptr_d = w_wr_en ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        count_d  = count_q + (AW + 1)'(w_wr_en) - (AW + 1)'(w_pop);
        ovf_d    = ovf_q || (w_push && w_full && !w_pop);

        // Head register tracks the entry that rd_ptr will point at next cycle;
        // when the FIFO drains it simply keeps its last value.
        uart_in_d = uart_in_q;
        if (w_wr_en && w_empty) begin
            uart_in_d = shift_q;
        end else if (w_pop) begin
            if (count_q > (AW + 1)'(1)) begin
                uart_in_d = mem_q[w_rd_next];
            end else if (w_wr_en) begin
                uart_in_d = shift_q;
            end
        end
    end

    // FIFO storage; contents need no reset since the head is held separately
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // FIFO pointers, occupancy, head byte and sticky overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            uart_in_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            uart_in_q <= uart_in_d;
            ovf_q     <= ovf_d;
        end
    end

    assign uart_in    = uart_in_q;
    assign empty      = w_empty;
    assign full       = w_full;
    assign uart_ok_in = !w_empty;
    assign overflow   = ovf_q;
    assign frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed self-checking bench for uart_rx_fifo
//               (CLK_PER_BIT = 16, DEPTH = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       rxd = 1'b1;
    logic       m_in = 1'b0;
    logic [7:0] uart_in;
    logic       uart_ok_in, empty, full, overflow, frame_err;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_rx_fifo #(
        .CLK_PER_BIT(CPB),
        .DEPTH      (4)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rxd       (rxd),
        .m_in      (m_in),
        .uart_in   (uart_in),
        .uart_ok_in(uart_ok_in),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hold one bit on the line for a full bit period (starts and ends on a negedge)
    task automatic drive_bit(input logic v);
        rxd = v;
        repeat (CPB) @(negedge clk);
    endtask

    // Start + 8 data bits, then the stop level; returns 10 cycles into the stop
    // bit, i.e. the negedge just before the stop sample edge.
    task automatic frame_pre(input logic [7:0] d, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        rxd = stop;
        repeat (10) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        frame_pre(d, 1'b1);
        repeat (6) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Check the head byte, then pulse m_in for one cycle
    task automatic pop_check(input string tag, input logic [7:0] exp);
        check(tag, uart_in, exp);
        m_in = 1'b1;
        @(negedge clk);
        m_in = 1'b0;
    endtask

    logic saw_ferr;

    initial begin
        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_empty", empty, 1'b1);
        check("rst_ok", uart_ok_in, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        check("rst_data", uart_in, 8'h00);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // ---------------- single byte, exact latency ----------------
        frame_pre(8'hA5, 1'b1);
        check("lat_before", uart_ok_in, 1'b0);
        @(negedge clk);
        check("lat_ok", uart_ok_in, 1'b1);
        check("lat_empty", empty, 1'b0);
        check("lat_data", uart_in, 8'hA5);
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        pop_check("single_pop", 8'hA5);
        check("single_empty", empty, 1'b1);
        m_in = 1'b1;                      // pop while empty is ignored
        @(negedge clk);
        m_in = 1'b0;
        check("underflow_empty", empty, 1'b1);

        // ---------------- ordering and pointer wrap ----------------
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        check("wrap_full", full, 1'b1);
        pop_check("wrap_r1", 8'h01);
        pop_check("wrap_r2", 8'h02);
        check("wrap_notfull", full, 1'b0);
        send(8'h05); send(8'h06);
        check("wrap_full2", full, 1'b1);
        pop_check("wrap_r3", 8'h03);
        pop_check("wrap_r4", 8'h04);
        pop_check("wrap_r5", 8'h05);
        pop_check("wrap_r6", 8'h06);
        check("wrap_empty", empty, 1'b1);
        check("wrap_ovf", overflow, 1'b0);

        // ---------------- framing error ----------------
        frame_pre(8'h5A, 1'b0);
        check("ferr_before", frame_err, 1'b0);
        @(negedge clk);
        check("ferr_pulse", frame_err, 1'b1);
        @(negedge clk);
        check("ferr_single", frame_err, 1'b0);
        saw_ferr = 1'b0;
        repeat (40) begin                 // line held low: no second flag
            @(negedge clk);
            saw_ferr = saw_ferr | frame_err;
        end
        check("break_once", saw_ferr, 1'b0);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        check("ferr_nopush", empty, 1'b1);

        // ---------------- start-bit glitch ----------------
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        saw_ferr = 1'b0;
        repeat (40) begin
            @(negedge clk);
            saw_ferr = saw_ferr | frame_err;
        end
        check("glitch_noferr", saw_ferr, 1'b0);
        check("glitch_nopush", empty, 1'b1);

        // ---------------- overflow ----------------
        send(8'h11); send(8'h12); send(8'h13); send(8'h14);
        send(8'h77);
        check("ovf_set", overflow, 1'b1);
        check("ovf_full", full, 1'b1);
        pop_check("ovf_r1", 8'h11);
        pop_check("ovf_r2", 8'h12);
        pop_check("ovf_r3", 8'h13);
        pop_check("ovf_r4", 8'h14);
        check("ovf_drop", empty, 1'b1);
        check("ovf_sticky", overflow, 1'b1);

        // ---------------- async reset mid-frame ----------------
        send(8'h41); send(8'h42);
        check("mid_queued", uart_in, 8'h41);
        drive_bit(1'b0);
        drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
        rxd = 1'b0;
        repeat (8) @(negedge clk);        // middle of bit 3
        rstn = 1'b0;
        #1;
        check("mid_empty", empty, 1'b1);
        check("mid_ok", uart_ok_in, 1'b0);
        check("mid_ovf", overflow, 1'b0);
        check("mid_full", full, 1'b0);
        check("mid_data", uart_in, 8'h00);
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (5) @(negedge clk);
        check("post_empty", empty, 1'b1);
        send(8'h3C);
        check("post_ok", uart_ok_in, 1'b1);
        pop_check("post_data", 8'h3C);
        check("post_drained", empty, 1'b1);

        // ---------------- push while full with simultaneous pop ----------------
        send(8'h21); send(8'h22); send(8'h23); send(8'h24);
        check("sim_full", full, 1'b1);
        check("sim_head", uart_in, 8'h21);
        frame_pre(8'h55, 1'b1);
        m_in = 1'b1;                      // pop in the stop-accept cycle
        @(negedge clk);
        m_in = 1'b0;
        check("sim_ovf", overflow, 1'b0);
        check("sim_still_full", full, 1'b1);
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (2) @(negedge clk);
        pop_check("sim_r1", 8'h22);
        pop_check("sim_r2", 8'h23);
        pop_check("sim_r3", 8'h24);
        pop_check("sim_r4", 8'h55);
        check("sim_empty", empty, 1'b1);
        check("sim_ovf_end", overflow, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Upstream feeder for the register file's UART-input path. Deserialises the 8N1 serial line and buffers received bytes in a FIFO.
- Presents the head byte together with empty/valid status to the pipeline.
- A byte is popped when the memory-stage input instruction (m_in) consumes it.
- Sits between the board RX pin and the register-file inputs uart_in, uart_ok_in and empty.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200). Must be ≥ 4.
- DEPTH, 16, FIFO entries. Must be a power of two, ≥ 2.
- AW, $clog2(DEPTH), pointer width (derived, not overridden).

Ports:
- clk  in  1  system clock
- rstn  in  1  reset: one clock; reset is asynchronous and active-low.
- rxd  in  1  serial input, idle high, asynchronous to clk
- m_in  in  1  memory-stage UART-input instruction; requests a pop
- uart_in  out  8  head-of-FIFO byte (first-word fall-through)
- uart_ok_in  out  1  head byte valid; equals ~empty
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- overflow  out  1  sticky: byte received while full
- frame_err  out  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (rstn low, asynchronous):
  - FSM enters IDLE; bit counter, baud counter and pointers clear; count = 0.
  - Outputs: uart_in = 0, empty = 1, uart_ok_in = 0, full = 0, overflow = 0, frame_err = 0.
  - Synchroniser flops reset to 1.
  - Reset mid-frame discards the partial byte; the FIFO contents are lost.
- Synchroniser: rxd passes through 2 flops (rx_s). All FSM decisions use rx_s plus a registered copy rx_d.
- RX FSM:
  - IDLE: on a falling edge (rx_d = 1, rx_s = 0), load the baud counter with CLK_PER_BIT/2 − 1 and go to START.
  - START: count down. At 0, if rx_s = 0, reload CLK_PER_BIT − 1, clear bit_idx and go to DATA. Otherwise it is a false start; return to IDLE with no push.
  - DATA: count down. At 0, shift rx_s into bit position bit_idx (LSB first) and reload. After bit_idx = 7 is sampled, go to STOP.
  - STOP: count down. At 0, if rx_s = 1, push the byte and go to IDLE. If rx_s = 0, pulse frame_err for 1 cycle, drop the byte and go to IDLE. IDLE then needs a fresh high-to-low edge, so a line held low (break) produces exactly one frame_err.
- Sample point is mid-bit: first data sample at 1.5·CLK_PER_BIT after the detected edge (± synchroniser delay of 2 cycles).
- FIFO:
  - DEPTH entries; read/write pointers of AW bits wrap modulo DEPTH.
  - count is AW+1 bits. empty = (count == 0), full = (count == DEPTH), both decoded from registered count.
  - pop = m_in & ~empty. A pop while empty is ignored; pointers do not move and no underflow is flagged.
  - push = STOP-accept. A push while full with no pop in the same cycle drops the byte and sets overflow. overflow clears only on reset.
  - Simultaneous push and pop: both take effect, count unchanged. This is legal when full (the pop frees the slot) and when count = 1.
  - Push into empty: the byte is visible on uart_in and uart_ok_in is high on the next cycle.
  - Pop: uart_in shows the next entry on the next cycle. When empty, uart_in holds its last value (don't-care to consumers).
- Latency: last stop-bit sample to uart_ok_in high is 1 cycle.
- Consumer contract: uart_ok_in & m_in in cycle N consumes exactly one byte. A stalled pipeline holding m_in high for k cycles pops up to k bytes, so the pipeline must pulse m_in for one cycle per instruction.

Test Plan (CLK_PER_BIT = 16, DEPTH = 4):
- Single byte: send 0xA5 8N1, m_in = 0 → 1 cycle after the stop sample, empty = 0, uart_ok_in = 1, uart_in = 0xA5. Pulse m_in for 1 cycle → next cycle empty = 1.
- Ordering and wrap: send 0x01..0x04 → full = 1. Pop 2; send 0x05, 0x06; pop 4 → bytes read in order 01,02,03,04,05,06. Pointers wrap and count returns to 0.
- Overflow: fill with 4 bytes, then send 0x77 with no pop → overflow = 1 and stays set. FIFO still holds the original 4 bytes; 0x77 is never observed.
- Full with simultaneous pop: FIFO full, assert m_in in the exact cycle of the stop-bit accept → overflow stays 0, count stays 4, new byte is last in order.
- Framing and glitch: stop bit driven low → single-cycle frame_err, no push. A 4-cycle low glitch on idle rxd → false start, no push, no frame_err.
- Async reset mid-frame: assert rstn low during bit 3 of a byte with 2 bytes queued → immediately empty = 1, count 0, overflow 0. After release, the next full frame 0x3C is received correctly.
